// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

   // Default first fetch address after reset
   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   // Default FIFO depth and in-flight request limit
   localparam int FETCH_DEPTH = 2;

   // Byte distance between consecutive RV32I instructions
   localparam logic [31:0] FETCH_STEP = 32'd4;

   // One buffered instruction together with the address it came from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_pkt_t;

   // Clear the byte-offset bits so the result is a word address
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch packets with flush
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   localparam int AW = $clog2(DEPTH)
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  fetch_pkt_t  push_data,
   input  logic        pop,
   input  logic        flush,
   output logic [AW:0] count,
   output fetch_pkt_t  head,
   output logic        empty,
   output logic        full
);

   fetch_pkt_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_do_push;
   logic          w_do_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == (AW+1)'(DEPTH));
   assign count = r_count;

   // Flush wins over everything; a push into a full FIFO is legal only
   // when the head leaves in the same cycle.
   assign w_do_pop  = pop && !empty && !flush;
   assign w_do_push = push && (!full || w_do_pop) && !flush;

   // Head is forced to zero while empty so outputs never show stale data
   assign head = empty ? '0 : r_mem[r_rd_ptr];

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage (optional FETCH_MISALIGN_CHK_EN)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter int          DEPTH    = FETCH_DEPTH
)
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        misalign
);

   localparam int              AW     = $clog2(DEPTH);
   localparam logic [AW+1:0]   L_DEPTH = (AW+2)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [AW:0]   r_drop_cnt;

   logic          w_misalign;
   logic          w_req_fire;
   logic          w_pop;
   logic          w_push;
   logic          w_resp_drop;
   logic [AW+1:0] w_credit_used;

   logic [AW:0]   w_fifo_count;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   fetch_pkt_t    w_head;
   fetch_pkt_t    w_resp_pkt;

   logic [AW:0]   w_outstanding;
   logic          w_pcq_empty;
   logic          w_pcq_full;
   fetch_pkt_t    w_pcq_head;
   fetch_pkt_t    w_pcq_push_data;

   assign w_pop      = instr_valid && instr_ready;
   assign w_req_fire = imem_req_valid && imem_req_ready;

   // Buffered plus in-flight words must fit in the FIFO. A slot popped
   // this cycle counts as free: the earliest response to a request issued
   // now lands next cycle, after the pop has taken effect. This keeps one
   // instruction per cycle flowing with DEPTH 2 and single-cycle memory.
   assign w_credit_used = {1'b0, w_fifo_count}
                        - {{(AW+1){1'b0}}, w_pop}
                        + {1'b0, w_outstanding};

   assign imem_req_valid = !reset && !redirect && !w_misalign
                           && (w_credit_used < L_DEPTH);
   assign imem_req_addr  = r_fetch_pc;

   // A response is stale if it belongs to a request issued before a
   // redirect, including one that arrives in the redirect cycle itself.
   assign w_resp_drop = (r_drop_cnt != '0) || redirect;
   assign w_push      = imem_resp_valid && !w_resp_drop;

   assign w_pcq_push_data = '{pc: r_fetch_pc, instr: 32'h0000_0000};
   assign w_resp_pkt      = '{pc: w_pcq_head.pc, instr: imem_resp_data};

   // PCs of accepted requests, popped in order as responses return; its
   // occupancy is the outstanding-request count. Never flushed, so stale
   // responses still consume their own PC entry.
   fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
      .clk       (clk),
      .rst       (reset),
      .push      (w_req_fire),
      .push_data (w_pcq_push_data),
      .pop       (imem_resp_valid),
      .flush     (1'b0),
      .count     (w_outstanding),
      .head      (w_pcq_head),
      .empty     (w_pcq_empty),
      .full      (w_pcq_full)
   );

   // Instruction buffer toward decode; redirect empties it after any
   // same-cycle head handshake.
   fetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (w_push),
      .push_data (w_resp_pkt),
      .pop       (w_pop),
      .flush     (redirect),
      .count     (w_fifo_count),
      .head      (w_head),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full)
   );

   assign instr_valid = !w_fifo_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;
   assign misalign    = w_misalign;

`ifdef FETCH_MISALIGN_CHK_EN
   logic r_misalign;

   assign w_misalign = r_misalign;

   // Latch whether the most recent redirect target was misaligned
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_misalign <= 1'b0;
      end else if (redirect) begin
         r_misalign <= (redirect_pc[1:0] != 2'b00);
      end
   end

   // Fetch PC: aligned redirect loads the target, misaligned keeps the
   // old value since issue is blocked until the next aligned redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         if (redirect_pc[1:0] == 2'b00) begin
            r_fetch_pc <= redirect_pc;
         end
      end else if (w_req_fire) begin
         r_fetch_pc <= r_fetch_pc + FETCH_STEP;
      end
   end

   logic w_unused;
   assign w_unused = &{w_pcq_empty, w_pcq_full, w_pcq_head.instr, w_fifo_full};
`else
   assign w_misalign = 1'b0;

   // Fetch PC: redirect target is forced to a word boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= word_align(redirect_pc);
      end else if (w_req_fire) begin
         r_fetch_pc <= r_fetch_pc + FETCH_STEP;
      end
   end

   logic w_unused;
   assign w_unused = &{w_pcq_empty, w_pcq_full, w_pcq_head.instr, w_fifo_full,
                       redirect_pc[1:0]};
`endif

   // Count of in-flight responses to discard; recomputed on every redirect
   // from the live outstanding count less any response landing right now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (redirect) begin
         r_drop_cnt <= w_outstanding - {{AW{1'b0}}, imem_resp_valid};
      end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
         r_drop_cnt <= r_drop_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   mem_req_t   pend[$];
   fetch_pkt_t exp_q[$];

   int total = 0;
   int bad = 0;
   int pops = 0;
   int req_cnt = 0;
   int cyc = 0;
   int lat = 1;

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .misalign        (misalign)
   );

   always #5 clk = ~clk;

   // Memory contents: low address bits shifted up, ADDI-like low byte
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic exp_stream(input logic [31:0] start, input int n);
      logic [31:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{pc: a, instr: mem_word(a)});
         a = a + 32'd4;
      end
   endtask

   task automatic wait_pops(input int n);
      int target;
      target = pops + n;
      for (int i = 0; i < 300; i++) begin
         if (pops >= target) break;
         @(negedge clk);
      end
      check("pops_progress", 32'(pops >= target), 32'd1);
   endtask

   // In-order memory with programmable latency, cleared by reset
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         pend.delete();
         req_cnt = 0;
         imem_resp_valid <= 1'b0;
         imem_resp_data  <= 32'h0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + lat - 1});
            req_cnt++;
         end
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_resp_valid <= 1'b0;
         end
      end
   end

   // Scoreboard monitor: every decode handshake is matched against the queue
   always @(negedge clk) begin
      fetch_pkt_t e;
      if (!reset && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: actual pc=%h instr=%h required=no instruction",
                     instr_pc, instr);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", instr_pc, e.pc);
            check("sb_instr", instr, e.instr);
         end
         pops++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int found;
      int p0;
      int rc;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);

      // Start-up with decode stalled
      exp_stream(32'h0, 64);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("c0_req_valid", 32'(imem_req_valid), 32'd1);
      check("c0_req_addr", imem_req_addr, 32'h0);
      check("c0_instr_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("c1_instr_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("c2_instr_valid", 32'(instr_valid), 32'd1);
      check("c2_instr_pc", instr_pc, 32'h0);
      repeat (10) @(negedge clk);
      check("stall_req_cnt", 32'(req_cnt), 32'd2);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_hold_pc", instr_pc, 32'h0);
      check("stall_hold_instr", instr, mem_word(32'h0));

      // Release decode: drain in order, then one instruction per cycle
      @(posedge clk); #1 instr_ready = 1'b1;
      found = 0;
      repeat (8) begin
         @(negedge clk);
         if (instr_valid) found++;
      end
      check("throughput_streak", 32'(found), 32'd8);

      // Three-cycle memory, redirect with two requests in flight
      @(posedge clk); #1 lat = 3;
      found = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (pend.size() == 2 && !imem_resp_valid) begin
            found = 1;
            break;
         end
      end
      check("two_in_flight_seen", 32'(found), 32'd1);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0100;
      @(posedge clk); #1;
      redirect = 1'b0;
      exp_q.delete();
      exp_stream(32'h0000_0100, 64);
      @(negedge clk);
      check("redir_b_flushed", 32'(instr_valid), 32'd0);
      wait_pops(4);

      // Redirect coinciding with a response and a decode handshake
      @(posedge clk); #1 lat = 1;
      repeat (4) @(posedge clk);
      found = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (imem_resp_valid && instr_valid) begin
            found = 1;
            break;
         end
      end
      check("resp_and_hs_seen", 32'(found), 32'd1);
      p0 = pops;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      @(posedge clk); #1;
      check("redir_hs_completed", 32'(pops), 32'(p0 + 1));
      redirect = 1'b0;
      exp_q.delete();
      exp_stream(32'hFFFF_FFF8, 64);
      @(negedge clk);
      check("redir_c_flushed", 32'(instr_valid), 32'd0);
      wait_pops(6);

      // Misaligned redirect target
      @(posedge clk); #1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0102;
      @(posedge clk); #1;
      redirect = 1'b0;
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      rc = req_cnt;
      @(negedge clk);
      check("mis_flag_set", 32'(misalign), 32'd1);
      check("mis_req_blocked", 32'(imem_req_valid), 32'd0);
      repeat (5) @(negedge clk);
      check("mis_no_requests", 32'(req_cnt), 32'(rc));
      check("mis_fifo_empty", 32'(instr_valid), 32'd0);
      @(posedge clk); #1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(posedge clk); #1;
      redirect = 1'b0;
      exp_stream(32'h0000_0200, 64);
      @(negedge clk);
      check("mis_flag_clear", 32'(misalign), 32'd0);
      wait_pops(3);
`else
      rc = 0;
      exp_stream(32'h0000_0100, 64);
      @(negedge clk);
      check("mis_flag_tied", 32'(misalign), 32'(rc));
      wait_pops(3);
`endif

      // Reset in the middle of streaming
      @(posedge clk); #1 reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_instr_valid", 32'(instr_valid), 32'd0);
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("midrst_instr_pc", instr_pc, 32'h0);
      check("midrst_misalign", 32'(misalign), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
